// File: rtl/digit_overlay_gen.sv
// Digit overlay: composites NUM_DIGITS BCD glyphs from an external glyph ROM onto a pixel stream (blink: DIGIT_OVERLAY_BLINK_EN).
// Latency: exactly 2 clka cycles from h_cnt/v_cnt/bg_pixel to pixel_out/hit, one pixel per cycle.
// Backpressure: none; the video stream is never stalled.
module digit_overlay_gen #(
  parameter int NUM_DIGITS   = 4,
  parameter int GLYPH_W      = 64,
  parameter int GLYPH_H      = 64,
  parameter int GAP          = 0,
  parameter int BLINK_FRAMES = 30,
  parameter int ADDR_W       = $clog2(10 * GLYPH_W * GLYPH_H)
) (
  input  logic                    clka,
  input  logic                    rst,
  input  logic [9:0]              h_cnt,
  input  logic [9:0]              v_cnt,
  input  logic [11:0]             bg_pixel,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [9:0]              origin_x,
  input  logic [9:0]              origin_y,
  input  logic [11:0]             fg_color,
  input  logic                    lz_suppress,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic                    rom_data,
  output logic [11:0]             pixel_out,
  output logic                    hit
);

  localparam int PITCH    = GLYPH_W + GAP;
  localparam int REGION_W = NUM_DIGITS * PITCH - GAP;

  logic                    fs;
  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [9:0]              sh_ox;
  logic [9:0]              sh_oy;
  logic [11:0]             sh_fg;
  logic                    sh_lz;
  logic                    sh_valid;
  logic [NUM_DIGITS-1:0]   blank_mask;

  assign fs = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  always_ff @(posedge clka) begin
    if (rst) begin
      sh_digits <= '0;
      sh_ox     <= '0;
      sh_oy     <= '0;
      sh_fg     <= '0;
      sh_lz     <= 1'b0;
      sh_valid  <= 1'b0;
    end else if (fs) begin
      sh_digits <= digits;
      sh_ox     <= origin_x;
      sh_oy     <= origin_y;
      sh_fg     <= fg_color;
      sh_lz     <= lz_suppress;
      sh_valid  <= 1'b1;
    end
  end

`ifdef DIGIT_OVERLAY_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0]       frame_cnt;
  logic                  blink_phase;
  logic                  sh_phase;
  logic [NUM_DIGITS-1:0] sh_blink;

  // The shadow takes the phase from before this FS's update, so a toggle shows from the following frame.
  always_ff @(posedge clka) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_phase    <= 1'b0;
      sh_blink    <= '0;
    end else if (fs) begin
      sh_phase <= blink_phase;
      sh_blink <= blink_mask;
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blank_mask = sh_phase ? sh_blink : '0;
`else
  logic unused_blink;
  assign unused_blink = &{1'b0, blink_mask};
  assign blank_mask   = '0;
`endif

  // 11-bit differences: bit 10 set means the scan position is left of / above the origin.
  logic [10:0]       dx;
  logic [10:0]       dy;
  logic [31:0]       xoff;
  logic [31:0]       yoff;
  logic [31:0]       slot;
  logic [31:0]       col;
  logic              in_region;
  logic              lead_zero;
  logic [3:0]        d_sel;
  logic              vis_sel;
  logic              hit_c;
  logic [ADDR_W-1:0] addr_c;

  assign dx        = {1'b0, h_cnt} - {1'b0, sh_ox};
  assign dy        = {1'b0, v_cnt} - {1'b0, sh_oy};
  assign xoff      = {21'd0, dx};
  assign yoff      = {21'd0, dy};
  assign slot      = xoff / 32'(PITCH);
  assign col       = xoff % 32'(PITCH);
  assign in_region = !dx[10] && !dy[10] && (xoff < 32'(REGION_W)) && (yoff < 32'(GLYPH_H));

  always_comb begin
    lead_zero = 1'b1;
    d_sel     = 4'd0;
    vis_sel   = 1'b0;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      lead_zero = lead_zero && (sh_digits[4*(NUM_DIGITS-1-s) +: 4] == 4'd0);
      if (slot == 32'(s)) begin
        d_sel   = sh_digits[4*(NUM_DIGITS-1-s) +: 4];
        vis_sel = sh_valid && (d_sel <= 4'd9) &&
                  !(sh_lz && lead_zero && (s != NUM_DIGITS - 1)) &&
                  !blank_mask[NUM_DIGITS-1-s];
      end
    end
  end

  assign hit_c  = in_region && (col < 32'(GLYPH_W)) && vis_sel;
  assign addr_c = ADDR_W'(32'(d_sel) * 32'(GLYPH_W * GLYPH_H) + yoff * 32'(GLYPH_W) + col);

  logic        hit_s1;
  logic [11:0] bg_s1;
  logic [11:0] fg_s1;

  always_ff @(posedge clka) begin
    if (rst) begin
      rom_addr  <= '0;
      hit_s1    <= 1'b0;
      bg_s1     <= '0;
      fg_s1     <= '0;
      pixel_out <= '0;
      hit       <= 1'b0;
    end else begin
      rom_addr  <= hit_c ? addr_c : '0;
      hit_s1    <= hit_c;
      bg_s1     <= bg_pixel;
      fg_s1     <= sh_fg;
      pixel_out <= (hit_s1 && rom_data) ? fg_s1 : bg_s1;
      hit       <= hit_s1;
    end
  end

endmodule

// File: tb/tb_digit_overlay_gen.sv
// Directed bench for digit_overlay_gen: default instance plus a GAP=8 / BLINK_FRAMES=2 instance on shared stimulus.
module tb_digit_overlay_gen;

  logic        clka = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt, origin_x, origin_y;
  logic [11:0] bg_pixel, fg_color;
  logic [15:0] digits;
  logic        lz_suppress;
  logic [3:0]  blink_mask;
  logic [15:0] rom_addr, rom_addr2;
  logic        rom_data, rom_data2;
  logic [11:0] pixel_out, pixel_out2;
  logic        hit, hit2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] c_addr, c_addr2;
  logic [11:0] c_pix, c_pix2;
  logic        c_hit, c_hit2;

  always #5 clka = ~clka;

  // Glyph ROM model: even addresses are lit, read with the address registered by the DUT.
  assign rom_data  = ~rom_addr[0];
  assign rom_data2 = ~rom_addr2[0];

  digit_overlay_gen dut (
    .clka(clka), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .bg_pixel(bg_pixel),
    .digits(digits), .origin_x(origin_x), .origin_y(origin_y), .fg_color(fg_color),
    .lz_suppress(lz_suppress), .blink_mask(blink_mask), .rom_addr(rom_addr),
    .rom_data(rom_data), .pixel_out(pixel_out), .hit(hit)
  );

  digit_overlay_gen #(.GAP(8), .BLINK_FRAMES(2)) dut2 (
    .clka(clka), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .bg_pixel(bg_pixel),
    .digits(digits), .origin_x(origin_x), .origin_y(origin_y), .fg_color(fg_color),
    .lz_suppress(lz_suppress), .blink_mask(blink_mask), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .pixel_out(pixel_out2), .hit(hit2)
  );

  task automatic put(input logic [9:0] h, input logic [9:0] v, input logic [11:0] bg);
    @(negedge clka);
    h_cnt = h; v_cnt = v; bg_pixel = bg;
  endtask

  task automatic fs();
    put(10'd0, 10'd0, 12'h000);
  endtask

  // Drives one pixel, then captures its stage-1 address and stage-2 outputs at their exact cycles.
  task automatic run_px(input logic [9:0] h, input logic [9:0] v, input logic [11:0] bg);
    put(h, v, bg);
    put(10'd1023, 10'd1023, 12'h000);
    c_addr = rom_addr; c_addr2 = rom_addr2;
    put(10'd1023, 10'd1023, 12'h000);
    c_pix = pixel_out; c_hit = hit; c_pix2 = pixel_out2; c_hit2 = hit2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    digits = 16'h1234; origin_x = 10'd100; origin_y = 10'd50; fg_color = 12'hD1D;
    lz_suppress = 1'b0; blink_mask = 4'b0000;
    run_px(10'd100, 10'd50, 12'h456);
    n_cmp++; if (c_addr !== 16'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", c_addr); end
    n_cmp++; if (c_pix !== 12'h000) begin n_bad++; $display("FAIL reset_pix: got %h want 000", c_pix); end
    n_cmp++; if (c_hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit: got %b want 0", c_hit); end
    fs();
    put(10'd1023, 10'd1023, 12'h000);
    rst = 1'b0;
    run_px(10'd100, 10'd50, 12'h456);
    n_cmp++; if (c_hit !== 1'b0) begin n_bad++; $display("FAIL postreset_hit: got %b want 0", c_hit); end
    n_cmp++; if (c_addr !== 16'd0) begin n_bad++; $display("FAIL postreset_addr: got %0d want 0", c_addr); end
    n_cmp++; if (c_pix !== 12'h456) begin n_bad++; $display("FAIL postreset_pix: got %h want 456", c_pix); end
  endtask

  task automatic test_basic();
    fs();
    run_px(10'd100, 10'd50, 12'h0AB);
    n_cmp++; if (c_addr !== 16'd4096) begin n_bad++; $display("FAIL basic_addr0: got %0d want 4096", c_addr); end
    n_cmp++; if (c_hit !== 1'b1) begin n_bad++; $display("FAIL basic_hit0: got %b want 1", c_hit); end
    n_cmp++; if (c_pix !== 12'hD1D) begin n_bad++; $display("FAIL basic_pix0: got %h want D1D", c_pix); end
    run_px(10'd101, 10'd50, 12'h0CD);
    n_cmp++; if (c_addr !== 16'd4097) begin n_bad++; $display("FAIL basic_addr1: got %0d want 4097", c_addr); end
    n_cmp++; if (c_pix !== 12'h0CD) begin n_bad++; $display("FAIL basic_pix1: got %h want 0CD", c_pix); end
    run_px(10'd165, 10'd52, 12'h123);
    n_cmp++; if (c_addr !== 16'd8321) begin n_bad++; $display("FAIL basic_addr_s1: got %0d want 8321", c_addr); end
    n_cmp++; if (c_hit !== 1'b1) begin n_bad++; $display("FAIL basic_hit_s1: got %b want 1", c_hit); end
    run_px(10'd99, 10'd50, 12'h321);
    n_cmp++; if (c_hit !== 1'b0) begin n_bad++; $display("FAIL basic_left_hit: got %b want 0", c_hit); end
    n_cmp++; if (c_pix !== 12'h321) begin n_bad++; $display("FAIL basic_left_pix: got %h want 321", c_pix); end
    run_px(10'd355, 10'd113, 12'h0F0);
    n_cmp++; if (c_addr !== 16'd20479) begin n_bad++; $display("FAIL basic_corner_addr: got %0d want 20479", c_addr); end
    n_cmp++; if (c_hit !== 1'b1) begin n_bad++; $display("FAIL basic_corner_hit: got %b want 1", c_hit); end
    run_px(10'd356, 10'd50, 12'h0F0);
    n_cmp++; if (c_hit !== 1'b0) begin n_bad++; $display("FAIL basic_right_hit: got %b want 0", c_hit); end
    run_px(10'd100, 10'd114, 12'h0F0);
    n_cmp++; if (c_hit !== 1'b0) begin n_bad++; $display("FAIL basic_below_hit: got %b want 0", c_hit); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_pix;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) put(10'(100 + i), 10'd50, 12'(12'h100 + i));
      else       put(10'd1023, 10'd1023, 12'h000);
      if (i >= 2) begin
        exp_pix = ((i - 2) % 2 == 0) ? 12'hD1D : 12'(12'h100 + i - 2);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL b2b_hit[%0d]: got %b want 1", i - 2, hit); end
        n_cmp++; if (pixel_out !== exp_pix) begin n_bad++; $display("FAIL b2b_pix[%0d]: got %h want %h", i - 2, pixel_out, exp_pix); end
      end
    end
  endtask

  task automatic test_gap();
    origin_x = 10'd0; origin_y = 10'd0; digits = 16'h0200;
    fs();
    for (int h = 64; h < 72; h++) begin
      run_px(10'(h), 10'd0, 12'(12'h200 + h));
      n_cmp++; if (c_hit2 !== 1'b0) begin n_bad++; $display("FAIL gap_hit[%0d]: got %b want 0", h, c_hit2); end
      n_cmp++; if (c_pix2 !== 12'(12'h200 + h)) begin n_bad++; $display("FAIL gap_pix[%0d]: got %h want %h", h, c_pix2, 12'(12'h200 + h)); end
    end
    run_px(10'd72, 10'd0, 12'h777);
    n_cmp++; if (c_addr2 !== 16'd8192) begin n_bad++; $display("FAIL gap_slot1_addr: got %0d want 8192", c_addr2); end
    n_cmp++; if (c_hit2 !== 1'b1) begin n_bad++; $display("FAIL gap_slot1_hit: got %b want 1", c_hit2); end
    n_cmp++; if (c_pix2 !== 12'hD1D) begin n_bad++; $display("FAIL gap_slot1_pix: got %h want D1D", c_pix2); end
    run_px(10'd63, 10'd0, 12'h777);
    n_cmp++; if (c_addr2 !== 16'd63) begin n_bad++; $display("FAIL gap_slot0_addr: got %0d want 63", c_addr2); end
  endtask

  task automatic test_lz();
    origin_x = 10'd100; origin_y = 10'd50; lz_suppress = 1'b1; digits = 16'h0005;
    fs();
    for (int s = 0; s < 3; s++) begin
      run_px(10'(100 + 64 * s), 10'd50, 12'h000);
      n_cmp++; if (c_hit !== 1'b0) begin n_bad++; $display("FAIL lz5_hit_slot%0d: got %b want 0", s, c_hit); end
    end
    run_px(10'd292, 10'd50, 12'h000);
    n_cmp++; if (c_addr !== 16'd20480) begin n_bad++; $display("FAIL lz5_addr: got %0d want 20480", c_addr); end
    n_cmp++; if (c_pix !== 12'hD1D) begin n_bad++; $display("FAIL lz5_pix: got %h want D1D", c_pix); end
    digits = 16'h0000;
    fs();
    run_px(10'd228, 10'd50, 12'h000);
    n_cmp++; if (c_hit !== 1'b0) begin n_bad++; $display("FAIL lz0_slot2_hit: got %b want 0", c_hit); end
    run_px(10'd292, 10'd50, 12'h000);
    n_cmp++; if (c_hit !== 1'b1) begin n_bad++; $display("FAIL lz0_slot3_hit: got %b want 1", c_hit); end
    digits = 16'h0050;
    fs();
    run_px(10'd228, 10'd50, 12'h000);
    n_cmp++; if (c_addr !== 16'd20480) begin n_bad++; $display("FAIL lz50_slot2_addr: got %0d want 20480", c_addr); end
    run_px(10'd292, 10'd50, 12'h000);
    n_cmp++; if (c_hit !== 1'b1) begin n_bad++; $display("FAIL lz50_slot3_hit: got %b want 1", c_hit); end
    lz_suppress = 1'b0;
  endtask

  task automatic test_midframe_invalid_clip();
    digits = 16'h1111;
    fs();
    run_px(10'd100, 10'd50, 12'h000);
    n_cmp++; if (c_addr !== 16'd4096) begin n_bad++; $display("FAIL mid_before_addr: got %0d want 4096", c_addr); end
    digits = 16'h2222;
    run_px(10'd164, 10'd50, 12'h000);
    n_cmp++; if (c_addr !== 16'd4096) begin n_bad++; $display("FAIL mid_held_addr: got %0d want 4096", c_addr); end
    run_px(10'd228, 10'd51, 12'h000);
    n_cmp++; if (c_addr !== 16'd4160) begin n_bad++; $display("FAIL mid_held_addr2: got %0d want 4160", c_addr); end
    fs();
    run_px(10'd164, 10'd50, 12'h000);
    n_cmp++; if (c_addr !== 16'd8192) begin n_bad++; $display("FAIL mid_after_addr: got %0d want 8192", c_addr); end
    digits = 16'h1A34;
    fs();
    run_px(10'd164, 10'd50, 12'h000);
    n_cmp++; if (c_hit !== 1'b0) begin n_bad++; $display("FAIL inv_hit: got %b want 0", c_hit); end
    n_cmp++; if (c_addr !== 16'd0) begin n_bad++; $display("FAIL inv_addr: got %0d want 0", c_addr); end
    run_px(10'd228, 10'd50, 12'h000);
    n_cmp++; if (c_addr !== 16'd12288) begin n_bad++; $display("FAIL inv_next_addr: got %0d want 12288", c_addr); end
    digits = 16'h1234; origin_x = 10'd1000; origin_y = 10'd0;
    fs();
    for (int k = 0; k < 6; k++) begin
      logic [9:0] hv;
      case (k)
        0: hv = 10'd0;  1: hv = 10'd1;  2: hv = 10'd8;
        3: hv = 10'd23; 4: hv = 10'd24; default: hv = 10'd40;
      endcase
      run_px(hv, 10'd5, 12'h000);
      n_cmp++; if (c_hit !== 1'b0) begin n_bad++; $display("FAIL clip_hit[%0d]: got %b want 0", hv, c_hit); end
    end
    run_px(10'd1023, 10'd5, 12'h000);
    n_cmp++; if (c_addr !== 16'd4439) begin n_bad++; $display("FAIL clip_edge_addr: got %0d want 4439", c_addr); end
    n_cmp++; if (c_hit !== 1'b1) begin n_bad++; $display("FAIL clip_edge_hit: got %b want 1", c_hit); end
  endtask

`ifdef DIGIT_OVERLAY_BLINK_EN
  task automatic test_blink();
    logic exp_vis;
    digits = 16'h1234; origin_x = 10'd0; origin_y = 10'd0; blink_mask = 4'b0001;
    @(negedge clka); rst = 1'b1;
    put(10'd1023, 10'd1023, 12'h000);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      fs();
      run_px(10'd216, 10'd0, 12'h111);
      exp_vis = !(k == 3 || k == 4);
      n_cmp++; if (c_hit2 !== exp_vis) begin n_bad++; $display("FAIL blink_hit_fs%0d: got %b want %b", k, c_hit2, exp_vis); end
      n_cmp++; if (c_addr2 !== (exp_vis ? 16'd16384 : 16'd0)) begin n_bad++; $display("FAIL blink_addr_fs%0d: got %0d", k, c_addr2); end
    end
    @(negedge clka); rst = 1'b1;
    put(10'd1023, 10'd1023, 12'h000);
    rst = 1'b0;
    fs(); fs(); fs();
    run_px(10'd216, 10'd0, 12'h111);
    n_cmp++; if (c_hit2 !== 1'b0) begin n_bad++; $display("FAIL blink_frame3_hit: got %b want 0", c_hit2); end
    @(negedge clka); rst = 1'b1;
    put(10'd1023, 10'd1023, 12'h000);
    rst = 1'b0;
    run_px(10'd216, 10'd0, 12'h111);
    n_cmp++; if (c_hit2 !== 1'b0) begin n_bad++; $display("FAIL blink_rst_hit: got %b want 0", c_hit2); end
    for (int k = 1; k <= 3; k++) begin
      fs();
      run_px(10'd216, 10'd0, 12'h111);
      exp_vis = (k != 3);
      n_cmp++; if (c_hit2 !== exp_vis) begin n_bad++; $display("FAIL blink_rerun_fs%0d: got %b want %b", k, c_hit2, exp_vis); end
    end
    blink_mask = 4'b0000;
  endtask
`endif

  initial begin
    rst = 1'b1; h_cnt = 10'd1023; v_cnt = 10'd1023; bg_pixel = 12'h000;
    digits = 16'h0000; origin_x = 10'd0; origin_y = 10'd0; fg_color = 12'h000;
    lz_suppress = 1'b0; blink_mask = 4'b0000;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gap();
    test_lz();
    test_midframe_invalid_clip();
`ifdef DIGIT_OVERLAY_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
